// File: rtl/grid_io_bank_tile.sv
// Perimeter GPIO tile: NUM_SUBTILES pads, each with oe/inreg config cells written over a bl/wl bank,
// plus a registered config readback port, a write lock and a per-pad 2-flop input synchroniser.
module grid_io_bank_tile #(
  parameter int NUM_SUBTILES = 8,
  parameter int BL_WIDTH     = 4,
  parameter int WL_WIDTH     = 4,
  parameter int RD_AW        = 2
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset_n,
  inout  wire  [NUM_SUBTILES-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_SUBTILES-1:0] outpad,
  output logic [NUM_SUBTILES-1:0] inpad,
  input  logic [BL_WIDTH-1:0]     bl,
  input  logic [WL_WIDTH-1:0]     wl,
  input  logic                    cfg_lock,
  input  logic                    rd_en,
  input  logic [RD_AW-1:0]        rd_row,
  output logic [BL_WIDTH-1:0]     rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int NUM_CELLS = 2 * NUM_SUBTILES;
  localparam int MAP_BITS  = BL_WIDTH * WL_WIDTH;

  if (MAP_BITS < NUM_CELLS) begin : g_bad_geometry
    $error("grid_io_bank_tile: BL_WIDTH*WL_WIDTH too small for 2*NUM_SUBTILES cells");
  end
  if ((1 << RD_AW) < WL_WIDTH) begin : g_bad_rd_aw
    $error("grid_io_bank_tile: RD_AW too narrow to address WL_WIDTH rows");
  end

  // Cell k = 2*s + b (b=0 oe, b=1 inreg), located at row k/BL_WIDTH, column k%BL_WIDTH.
  logic [NUM_CELLS-1:0]    r_cells;
  logic [NUM_CELLS-1:0]    w_cell_we;
  logic [NUM_CELLS-1:0]    w_cell_d;
  logic [NUM_SUBTILES-1:0] w_oe;
  logic [NUM_SUBTILES-1:0] w_inreg;

  for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell_map
    assign w_cell_we[k] = ~cfg_lock & wl[k / BL_WIDTH];
    assign w_cell_d[k]  = bl[k % BL_WIDTH];
  end

  for (genvar s = 0; s < NUM_SUBTILES; s++) begin : g_cell_split
    assign w_oe[s]    = r_cells[2*s];
    assign w_inreg[s] = r_cells[2*s+1];
  end

  // NOTE: sequential state uses non-blocking assignments and every config cell is reset, so pads
  // come up tri-stated and no X ever reaches the fabric or the pads.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_cells <= '0;
    end else begin
      r_cells <= (r_cells & ~w_cell_we) | (w_cell_d & w_cell_we);
    end
  end

  for (genvar s = 0; s < NUM_SUBTILES; s++) begin : g_pad_drive
    assign gfpga_pad_GPIO_PAD[s] = w_oe[s] ? outpad[s] : 1'bz;
  end

  // Synchroniser samples the resolved pad, so a driven pad loops back to inpad.
  logic [NUM_SUBTILES-1:0] r_sync1;
  logic [NUM_SUBTILES-1:0] r_sync2;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gfpga_pad_GPIO_PAD;
      r_sync2 <= r_sync1;
    end
  end

  assign inpad = (w_inreg & r_sync2) | (~w_inreg & gfpga_pad_GPIO_PAD);

  // Readback view: unimplemented positions are constant zero.
  logic [MAP_BITS-1:0] w_map;
  logic [BL_WIDTH-1:0] w_rd_row;
  logic                w_row_ok;

  always_comb begin
    w_map                  = '0;
    w_map[NUM_CELLS-1:0]   = r_cells;
  end

  always_comb begin
    w_rd_row = '0;
    for (int r = 0; r < WL_WIDTH; r++) begin
      if (32'(rd_row) == r) w_rd_row = w_map[r*BL_WIDTH +: BL_WIDTH];
    end
  end

  assign w_row_ok = (32'(rd_row) < WL_WIDTH);

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= w_row_ok ? w_rd_row : '0;
      rd_valid <= 1'b1;
      rd_err   <= ~w_row_ok;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grid_io_bank_tile.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cell-map reference model,
// on a default 8-subtile 4x4 tile (A) and a 5-subtile 4x3 tile (B) for out-of-range/unimplemented reads.
module tb_grid_io_bank_tile;

  localparam int N  = 8;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wire  [N-1:0]  pad_a;
  wire  [NB-1:0] pad_b;
  logic [N-1:0]  outpad_a, inpad_a, tb_en, tb_val;
  logic [NB-1:0] outpad_b, inpad_b;
  logic [3:0]    bl, wl;
  logic          cfg_lock, rd_en;
  logic [1:0]    rd_row;
  logic [3:0]    rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_err_a, rd_valid_b, rd_err_b;

  for (genvar i = 0; i < N; i++) begin : g_pad_a
    assign pad_a[i] = tb_en[i] ? tb_val[i] : 1'bz;
    pulldown (pad_a[i]);
  end
  for (genvar i = 0; i < NB; i++) begin : g_pad_b
    pulldown (pad_b[i]);
  end

  grid_io_bank_tile #(.NUM_SUBTILES(N), .BL_WIDTH(4), .WL_WIDTH(4), .RD_AW(2)) u_dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .gfpga_pad_GPIO_PAD(pad_a),
    .outpad(outpad_a), .inpad(inpad_a), .bl(bl), .wl(wl), .cfg_lock(cfg_lock),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a)
  );

  grid_io_bank_tile #(.NUM_SUBTILES(NB), .BL_WIDTH(4), .WL_WIDTH(3), .RD_AW(2)) u_dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .gfpga_pad_GPIO_PAD(pad_b),
    .outpad(outpad_b), .inpad(inpad_b), .bl(bl), .wl(wl[2:0]), .cfg_lock(cfg_lock),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cell k = 2*s+b lives at row k/4, column k%4.
  bit [15:0]     ma, mb;
  bit [N-1:0]    q_a[$];
  bit [NB-1:0]   q_b[$];
  bit            ev_a, ee_a, ev_b, ee_b;
  bit [3:0]      ed_a, ed_b;

  function automatic bit [15:0] wr_model(input bit [15:0] cells, input int ncells,
                                         input bit [3:0] w, input bit [3:0] b, input bit lock);
    for (int k = 0; k < ncells; k++)
      if (!lock && w[k/4]) cells[k] = b[k%4];
    return cells;
  endfunction

  function automatic bit [3:0] rd_model(input bit [15:0] cells, input int ncells,
                                        input int rows, input int row);
    bit [3:0] d = '0;
    for (int c = 0; c < 4; c++)
      if (row < rows && row*4 + c < ncells) d[c] = cells[row*4 + c];
    return d;
  endfunction

  function automatic bit [N-1:0] exp_pad_a();
    bit [N-1:0] p;
    for (int s = 0; s < N; s++) p[s] = ma[2*s] ? outpad_a[s] : (tb_en[s] & tb_val[s]);
    return p;
  endfunction

  function automatic bit [NB-1:0] exp_pad_b();
    bit [NB-1:0] p;
    for (int s = 0; s < NB; s++) p[s] = mb[2*s] ? outpad_b[s] : 1'b0;
    return p;
  endfunction

  function automatic bit [N-1:0] exp_inpad_a();
    bit [N-1:0] p = exp_pad_a();
    bit [N-1:0] r;
    for (int s = 0; s < N; s++) r[s] = ma[2*s+1] ? q_a[0][s] : p[s];
    return r;
  endfunction

  function automatic bit [NB-1:0] exp_inpad_b();
    bit [NB-1:0] p = exp_pad_b();
    bit [NB-1:0] r;
    for (int s = 0; s < NB; s++) r[s] = mb[2*s+1] ? q_b[0][s] : p[s];
    return r;
  endfunction

  task automatic reset_model();
    ma = '0; mb = '0;
    q_a = '{0, 0}; q_b = '{0, 0};
    ev_a = 0; ee_a = 0; ed_a = '0; ev_b = 0; ee_b = 0; ed_b = '0;
  endtask

  // External pad drive is withdrawn from any pad the DUT drives now or after the coming edge.
  task automatic fix_drive();
    bit [15:0] nxt = wr_model(ma, 16, wl, bl, cfg_lock);
    for (int s = 0; s < N; s++)
      if (ma[2*s] || nxt[2*s]) tb_en[s] = 1'b0;
  endtask

  task automatic tick();
    bit [N-1:0]  pa = exp_pad_a();
    bit [NB-1:0] pb = exp_pad_b();
    ev_a = rd_en; ee_a = rd_en && (int'(rd_row) >= 4);
    ev_b = rd_en; ee_b = rd_en && (int'(rd_row) >= 3);
    if (rd_en) begin
      ed_a = rd_model(ma, 16, 4, int'(rd_row));
      ed_b = rd_model(mb, 10, 3, int'(rd_row));
    end
    ma = wr_model(ma, 16, wl, bl, cfg_lock);
    mb = wr_model(mb, 10, {1'b0, wl[2:0]}, bl, cfg_lock);
    @(posedge clk); #1;
    q_a.push_back(pa); q_a.delete(0);
    q_b.push_back(pb); q_b.delete(0);
  endtask

  task automatic check_all();
    check("pad_a", 32'(pad_a), 32'(exp_pad_a()));
    check("inpad_a", 32'(inpad_a), 32'(exp_inpad_a()));
    check("rd_valid_a", 32'(rd_valid_a), 32'(ev_a));
    check("rd_err_a", 32'(rd_err_a), 32'(ee_a));
    if (ev_a) check("rd_data_a", 32'(rd_data_a), 32'(ed_a));
    check("pad_b", 32'(pad_b), 32'(exp_pad_b()));
    check("inpad_b", 32'(inpad_b), 32'(exp_inpad_b()));
    check("rd_valid_b", 32'(rd_valid_b), 32'(ev_b));
    check("rd_err_b", 32'(rd_err_b), 32'(ee_b));
    if (ev_b) check("rd_data_b", 32'(rd_data_b), 32'(ed_b));
  endtask

  task automatic set_in(input bit [3:0] w, input bit [3:0] b, input bit lock,
                        input bit re, input bit [1:0] row);
    wl = w; bl = b; cfg_lock = lock; rd_en = re; rd_row = row;
    fix_drive();
  endtask

  initial begin
    rst_n = 1'b0;
    outpad_a = '1; outpad_b = '1; tb_en = '0; tb_val = '0;
    wl = '0; bl = '0; cfg_lock = 1'b0; rd_en = 1'b0; rd_row = '0;
    reset_model();
    #2;
    check("rst_pad_a", 32'(pad_a), 32'h0);
    check("rst_inpad_a", 32'(inpad_a), 32'h0);
    check("rst_rd", {rd_data_a, rd_valid_a, rd_err_a}, 32'h0);
    check_all();
    #10 rst_n = 1'b1;

    // Row 0 <- 0101: oe0=1, inreg0=0, oe1=1, inreg1=0.
    set_in(4'b0001, 4'b0101, 0, 0, 0); tick(); check_all();
    set_in(4'b0000, 4'b0000, 0, 0, 0);
    check("t1_pads", 32'(pad_a), 32'h03);
    outpad_a = 8'h02; #1;
    check("t1_pads_follow", 32'(pad_a), 32'h02);
    check_all();

    // Same-cycle write of row 0 returns the pre-write contents; the next read sees 0.
    set_in(4'b0001, 4'b0000, 0, 1, 0); tick(); check_all();
    check("rd_pre_write", {rd_valid_a, rd_err_a, rd_data_a}, {1'b1, 1'b0, 4'b0101});
    set_in(4'b0000, 4'b0000, 0, 1, 0); tick(); check_all();
    check("rd_post_write", 32'(rd_data_a), 32'h0);

    // inreg[2]=1 via row 1; pad2 low then high, visible on the second edge after sampling.
    set_in(4'b0010, 4'b0010, 0, 0, 0); tick(); check_all();
    tb_en[2] = 1'b1; tb_val[2] = 1'b0;
    set_in(4'b0000, 4'b0000, 0, 0, 0);
    tick(); check_all(); tick(); check_all();
    tb_val[2] = 1'b1; tick();
    check("sync_1edge", 32'(inpad_a[2]), 32'h0); check_all();
    tick();
    check("sync_2edge", 32'(inpad_a[2]), 32'h1); check_all();
    set_in(4'b0010, 4'b0000, 0, 0, 0); tick(); check_all();
    tb_val[2] = 1'b0; #1;
    check("comb_follow", 32'(inpad_a[2]), 32'h0); check_all();

    // Out-of-range read on the 3-row tile.
    set_in(4'b0000, 4'b0000, 0, 1, 3); tick(); check_all();
    check("oor_b", {rd_valid_b, rd_err_b, rd_data_b}, {1'b1, 1'b1, 4'b0000});

    // Lock holds every cell; unlocked, the same stimulus sets all cells.
    for (int r = 0; r < 4; r++) begin
      set_in(4'b1111, 4'b1111, 1, 1, 2'(r)); tick(); check_all();
    end
    set_in(4'b1111, 4'b1111, 0, 0, 0); tick(); check_all();
    for (int r = 0; r < 4; r++) begin
      set_in(4'b0000, 4'b0000, 0, 1, 2'(r)); tick(); check_all();
      check("all_ones", 32'(rd_data_a), 32'hF);
    end
    outpad_a = 8'hA5; #1;
    check("all_driven", 32'(pad_a), 32'hA5);

    // Reset mid-operation: in-flight read pulse and pad drive drop immediately.
    outpad_a = '1;
    set_in(4'b0000, 4'b0000, 0, 1, 1); tick(); check_all();
    #4 rst_n = 1'b0; reset_model(); rd_en = 1'b0; #1;
    check("midrst_pads", 32'(pad_a), 32'h0);
    check("midrst_inpad", 32'(inpad_a), 32'h0);
    check("midrst_valid", 32'(rd_valid_a), 32'h0);
    check_all();
    #3 rst_n = 1'b1;
    tick(); check_all();
    check("no_pulse_after", 32'(rd_valid_a), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      outpad_a = N'($urandom); outpad_b = NB'($urandom);
      tb_val = N'($urandom); tb_en = N'($urandom);
      set_in(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 4'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom));
      tick(); check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
